mem_sched: RTL

Request scheduler between the instruction fetch unit, the data cache and the shared line-wide memory port. It replaces open-loop request forwarding with valid/ready handshakes on every side, a registered request stage, and data-first arbitration with bounded instruction starvation. It also keeps a tag table of outstanding transactions so that out-of-order memory responses are routed back to the requester that issued them.

---
 rtl/mem_sched_pkg.sv | 44 ++++
 rtl/mem_tag_table.sv | 73 +++++++
 rtl/mem_sched.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mem_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_sched_pkg
// Description : Shared types and helpers for the memory request scheduler:
//               requester source enum, tag-table entry struct and the
//               lowest-free-index priority encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_sched_pkg;

    // Which requester issued a transaction.
    typedef enum logic {
        SRC_INSTR = 1'b0,
        SRC_DATA  = 1'b1
    } src_e;

    // One outstanding-transaction slot.
    typedef struct packed {
        logic busy;
        src_e src;
    } tag_entry_t;

    // Upper bound on table depth supported by the encoder below.
    localparam int c_MAX_TAGS = 64;

    // Returns the lowest index i < n_entries with busy_vec[i] == 0, or
    // n_entries when every slot is busy. Scanning downwards lets the last
    // assignment win, which is the lowest free index.
    function automatic int f_lowest_free(
        input logic [c_MAX_TAGS-1:0] busy_vec,
        input int                    n_entries
    );
        int idx;
        idx = n_entries;
        for (int i = c_MAX_TAGS - 1; i >= 0; i--) begin
            if ((i < n_entries) && !busy_vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_tag_table.sv
`default_nettype none
// ============================================================================
// Module      : mem_tag_table
// Description : Table of outstanding memory transactions. Each slot holds a
//               busy flag and the requester that owns it. Offers the lowest
//               free slot as the allocation candidate and a full flag.
//   clk           in   clock, rising edge
//   rst           in   synchronous active-low reset, clears every slot
//   i_alloc       in   mark slot o_free_idx busy, owned by i_alloc_src
//   i_alloc_src   in   owner recorded on allocation
//   i_free        in   clear the busy flag of slot i_idx
//   i_idx         in   slot looked up / freed (response index)
//   o_idx_busy    out  busy flag of slot i_idx
//   o_idx_src     out  owner of slot i_idx
//   o_free_idx    out  lowest free slot (don't-care when o_full)
//   o_full        out  every slot busy
// Revision    : 1.0 - initial release
// ============================================================================
module mem_tag_table
    import mem_sched_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int IDX_W           = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_alloc,
    input  src_e             i_alloc_src,
    input  logic             i_free,
    input  logic [IDX_W-1:0] i_idx,
    output logic             o_idx_busy,
    output src_e             o_idx_src,
    output logic [IDX_W-1:0] o_free_idx,
    output logic             o_full
);

    tag_entry_t              r_table [MAX_OUTSTANDING];
    logic [c_MAX_TAGS-1:0]   w_busy_vec;
    logic                    w_all_busy;

    always_comb begin
        w_busy_vec = '0;
        w_all_busy = 1'b1;
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            w_busy_vec[i] = r_table[i].busy;
            w_all_busy    = w_all_busy & r_table[i].busy;
        end
    end

    // The candidate is drawn from slots that are free right now, so a slot
    // being freed this cycle is never also the allocation target.
    assign o_free_idx = IDX_W'(f_lowest_free(w_busy_vec, MAX_OUTSTANDING));
    assign o_full     = w_all_busy;
    assign o_idx_busy = r_table[i_idx].busy;
    assign o_idx_src  = r_table[i_idx].src;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                r_table[i] <= '{busy: 1'b0, src: SRC_INSTR};
            end
        end else begin
            if (i_alloc) begin
                r_table[o_free_idx] <= '{busy: 1'b1, src: i_alloc_src};
            end
            if (i_free) begin
                r_table[i_idx].busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_sched.sv
`default_nettype none
// ============================================================================
// Module      : mem_sched
// Description : Request scheduler between instruction fetch, data cache and a
//               shared line-wide memory port. Data-first arbitration with
//               bounded instruction starvation, a registered request stage
//               and a tag table routing out-of-order responses back to the
//               issuing requester.
//   clk, rst                      clock / synchronous active-low reset
//   i_instr_valid/o_instr_ready   instruction request handshake, i_instr_addr
//   i_data_valid/o_data_ready     data request handshake, i_data_addr,
//                                 i_data_wdata, i_data_write
//   o_mem_valid/i_mem_ready       memory request handshake, o_mem_addr,
//                                 o_mem_data, o_mem_write, o_mem_id
//   i_mem_resp_valid/_id/_data    memory response (no backpressure)
//   o_instr_resp_valid            instruction response strobe
//   o_data_resp_valid             data response strobe
//   o_resp_data                   response line shared by both strobes
//   o_err                         sticky: response to an unallocated id
// Revision    : 1.0 - initial release
// ============================================================================
module mem_sched
    import mem_sched_pkg::*;
#(
    parameter int PA_WIDTH        = 32,
    parameter int LINE_BYTES      = 16,
    parameter int ID_WIDTH        = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_instr_valid,
    output logic                      o_instr_ready,
    input  logic [PA_WIDTH-1:0]       i_instr_addr,
    input  logic                      i_data_valid,
    output logic                      o_data_ready,
    input  logic [PA_WIDTH-1:0]       i_data_addr,
    input  logic [LINE_BYTES*8-1:0]   i_data_wdata,
    input  logic                      i_data_write,
    output logic                      o_mem_valid,
    input  logic                      i_mem_ready,
    output logic [PA_WIDTH-1:0]       o_mem_addr,
    output logic [LINE_BYTES*8-1:0]   o_mem_data,
    output logic                      o_mem_write,
    output logic [ID_WIDTH-1:0]       o_mem_id,
    input  logic                      i_mem_resp_valid,
    input  logic [ID_WIDTH-1:0]       i_mem_resp_id,
    input  logic [LINE_BYTES*8-1:0]   i_mem_resp_data,
    output logic                      o_instr_resp_valid,
    output logic                      o_data_resp_valid,
    output logic [LINE_BYTES*8-1:0]   o_resp_data,
    output logic                      o_err
);

    localparam int c_LINE_W = LINE_BYTES * 8;
    localparam int c_IDX_W  = $clog2(MAX_OUTSTANDING);
    localparam int c_CNT_W  = $clog2(STARVE_LIMIT + 1);

    // Registered state
    logic                 r_ready_en;
    logic [c_CNT_W-1:0]   r_starve_cnt;
    logic                 r_mem_valid;
    logic [PA_WIDTH-1:0]  r_mem_addr;
    logic [c_LINE_W-1:0]  r_mem_data;
    logic                 r_mem_write;
    logic [ID_WIDTH-1:0]  r_mem_id;
    logic                 r_instr_resp_valid;
    logic                 r_data_resp_valid;
    logic [c_LINE_W-1:0]  r_resp_data;
    logic                 r_err;

    // Combinational
    logic                 w_full;
    logic [c_IDX_W-1:0]   w_free_idx;
    logic                 w_can_issue;
    logic                 w_grant_instr;
    logic                 w_acc_instr;
    logic                 w_acc_data;
    logic                 w_accept;
    src_e                 w_alloc_src;
    logic [c_IDX_W-1:0]   w_resp_idx;
    logic                 w_resp_in_range;
    logic                 w_idx_busy;
    src_e                 w_idx_src;
    logic                 w_resp_hit;
    logic [c_CNT_W-1:0]   w_starve_nxt;

    mem_tag_table #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .IDX_W           (c_IDX_W)
    ) u_tag_table (
        .clk         (clk),
        .rst         (rst),
        .i_alloc     (w_accept),
        .i_alloc_src (w_alloc_src),
        .i_free      (w_resp_hit),
        .i_idx       (w_resp_idx),
        .o_idx_busy  (w_idx_busy),
        .o_idx_src   (w_idx_src),
        .o_free_idx  (w_free_idx),
        .o_full      (w_full)
    );

    // r_ready_en holds readies low during reset and for the first cycle
    // after release; rst also gates them before the first clock edge.
    assign w_can_issue   = rst && r_ready_en && !w_full &&
                           (!r_mem_valid || i_mem_ready);
    assign w_grant_instr = i_instr_valid &&
                           (!i_data_valid || (r_starve_cnt == c_CNT_W'(STARVE_LIMIT)));
    assign o_instr_ready = w_can_issue && w_grant_instr;
    assign o_data_ready  = w_can_issue && !w_grant_instr;

    assign w_acc_instr = i_instr_valid && o_instr_ready;
    assign w_acc_data  = i_data_valid && o_data_ready;
    assign w_accept    = w_acc_instr || w_acc_data;
    assign w_alloc_src = w_acc_data ? SRC_DATA : SRC_INSTR;

    // Ids at or above the table depth can never match a slot.
    assign w_resp_in_range = 32'(i_mem_resp_id) < 32'(MAX_OUTSTANDING);
    assign w_resp_idx      = i_mem_resp_id[c_IDX_W-1:0];
    assign w_resp_hit      = i_mem_resp_valid && w_resp_in_range && w_idx_busy;

    // Starvation is counted in actual data acceptances while instruction
    // waits, so stalls on a full table do not push the count up.
    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (!i_instr_valid || w_acc_instr) begin
            w_starve_nxt = '0;
        end else if (w_acc_data && (r_starve_cnt != c_CNT_W'(STARVE_LIMIT))) begin
            w_starve_nxt = r_starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ready_en         <= 1'b0;
            r_starve_cnt       <= '0;
            r_mem_valid        <= 1'b0;
            r_mem_addr         <= '0;
            r_mem_data         <= '0;
            r_mem_write        <= 1'b0;
            r_mem_id           <= '0;
            r_instr_resp_valid <= 1'b0;
            r_data_resp_valid  <= 1'b0;
            r_resp_data        <= '0;
            r_err              <= 1'b0;
        end else begin
            r_ready_en   <= 1'b1;
            r_starve_cnt <= w_starve_nxt;

            if (w_accept) begin
                r_mem_valid <= 1'b1;
                r_mem_id    <= ID_WIDTH'(w_free_idx);
                if (w_acc_data) begin
                    r_mem_addr  <= i_data_addr;
                    r_mem_data  <= i_data_wdata;
                    r_mem_write <= i_data_write;
                end else begin
                    r_mem_addr  <= i_instr_addr;
                    r_mem_data  <= '0;
                    r_mem_write <= 1'b0;
                end
            end else if (i_mem_ready) begin
                r_mem_valid <= 1'b0;
            end

            r_instr_resp_valid <= w_resp_hit && (w_idx_src == SRC_INSTR);
            r_data_resp_valid  <= w_resp_hit && (w_idx_src == SRC_DATA);
            if (w_resp_hit) begin
                r_resp_data <= i_mem_resp_data;
            end
            if (i_mem_resp_valid && !w_resp_hit) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_mem_valid        = r_mem_valid;
    assign o_mem_addr         = r_mem_addr;
    assign o_mem_data         = r_mem_data;
    assign o_mem_write        = r_mem_write;
    assign o_mem_id           = r_mem_id;
    assign o_instr_resp_valid = r_instr_resp_valid;
    assign o_data_resp_valid  = r_data_resp_valid;
    assign o_resp_data        = r_resp_data;
    assign o_err              = r_err;

endmodule
`default_nettype wire
